// File: rtl/cpu_oci_dct_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_oci_dct_sequencer
// Brief    : Arbitrates itr/dtr trace frames, packs them into words, flushes
//            words to the trace sink and runs the end-of-test drain.
// Revision : 1.0  initial release
// ============================================================================
module cpu_oci_dct_sequencer #(
    parameter int FRAME_W         = 10,
    parameter int FRAMES_PER_WORD = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               itr_valid,
    input  logic [FRAME_W-1:0]                 itr_frame,
    output logic                               itr_ready,
    input  logic                               dtr_valid,
    input  logic [FRAME_W-1:0]                 dtr_frame,
    output logic                               dtr_ready,
    output logic                               out_valid,
    output logic [FRAME_W*FRAMES_PER_WORD-1:0] out_word,
    output logic [3:0]                         out_count,
    input  logic                               out_ready,
    output logic [FRAME_W*FRAMES_PER_WORD-1:0] dct_buffer,
    output logic [3:0]                         dct_count,
    input  logic                               test_ending,
    output logic                               test_has_ended
);

    localparam int         WORD_W            = FRAME_W * FRAMES_PER_WORD;
    localparam logic [3:0] c_frames_per_word = 4'(FRAMES_PER_WORD);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_FLUSH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              r_next;
    logic [WORD_W-1:0]   r_buffer;
    logic [3:0]          r_count;
    logic                r_out_valid;
    logic [WORD_W-1:0]   r_out_word;
    logic [3:0]          r_out_count;
    logic                r_ending;
    logic                r_last_dtr;
    logic                r_has_ended;

    logic                w_ending;
    logic                w_in_fill;
    logic                w_grant_itr;
    logic                w_grant_dtr;
    logic                w_accept;
    logic [FRAME_W-1:0]  w_frame;
    logic [3:0]          w_fill_count;
    logic [WORD_W-1:0]   w_fill_buffer;
    logic                w_load;

    always_comb begin
        w_ending    = r_ending | test_ending;
        w_in_fill   = (r_state == S_FILL) & ~reset;
        // Under contention the source that did not win last time goes first.
        w_grant_itr = itr_valid & (~dtr_valid | r_last_dtr);
        w_grant_dtr = dtr_valid & ~w_grant_itr;
        itr_ready   = w_in_fill & ~r_ending & w_grant_itr;
        dtr_ready   = w_in_fill & ~r_ending & w_grant_dtr;
        w_accept    = itr_ready | dtr_ready;
        w_frame     = itr_ready ? itr_frame : dtr_frame;

        w_fill_count  = r_count + 4'(w_accept);
        w_fill_buffer = r_buffer;
        for (int i = 0; i < FRAMES_PER_WORD; i++) begin
            if (w_accept && (r_count == 4'(i)))
                w_fill_buffer[i*FRAME_W +: FRAME_W] = w_frame;
        end

        r_next = r_state;
        w_load = 1'b0;
        case (r_state)
            S_FILL: begin
                if ((w_fill_count == c_frames_per_word) ||
                    (w_ending && (w_fill_count != 4'd0))) begin
                    r_next = S_FLUSH;
                    w_load = 1'b1;
                end else if (w_ending) begin
                    r_next = S_DONE;
                end
            end
            S_FLUSH: begin
                if (out_ready)
                    r_next = w_ending ? S_DONE : S_FILL;
            end
            S_DONE:  r_next = S_DONE;
            default: r_next = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_FILL;
        else
            r_state <= r_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buffer    <= '0;
            r_count     <= 4'd0;
            r_out_valid <= 1'b0;
            r_out_word  <= '0;
            r_out_count <= 4'd0;
            r_ending    <= 1'b0;
            r_last_dtr  <= 1'b1;
            r_has_ended <= 1'b0;
        end else begin
            r_ending    <= w_ending;
            r_has_ended <= (r_next == S_DONE);
            if (w_accept)
                r_last_dtr <= dtr_ready;
            if (r_state == S_FILL) begin
                r_buffer <= w_fill_buffer;
                r_count  <= w_fill_count;
                if (w_load) begin
                    r_out_word  <= w_fill_buffer;
                    r_out_count <= w_fill_count;
                    r_out_valid <= 1'b1;
                end
            end else if ((r_state == S_FLUSH) && out_ready) begin
                r_buffer    <= '0;
                r_count     <= 4'd0;
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign out_word       = r_out_word;
    assign out_count      = r_out_count;
    assign dct_buffer     = r_buffer;
    assign dct_count      = r_count;
    assign test_has_ended = r_has_ended;

endmodule
`default_nettype wire
